mod_inverse: RTL and testbench
==============================

# mod_inverse

Sequential modular-inverse unit for the public-key decryption datapath. It sits directly downstream of the GCD stage. Given public exponent `e` and totient `phi`, it runs the iterative extended Euclidean algorithm and returns the private exponent `d = e^-1 mod phi`, or flags that no inverse exists (`gcd(e, phi) != 1`). It uses a start/done handshake and one multi-cycle restoring divider per iteration.

## Interface
- `WIDTH`, default 8: operand and result width; matches the GCD stage's 8-bit datapath.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: request pulse; sampled only in IDLE.
- `e` input WIDTH: public exponent; captured when `start` is accepted.
- `phi` input WIDTH: modulus (totient); captured when `start` is accepted.
- `busy` output 1: high from the cycle after `start` is accepted through FINAL.
- `done` output 1: one-cycle pulse; `d`/`no_inverse` are valid from this cycle.
- `d` output WIDTH: inverse in range [0, phi-1]; forced to 0 when `no_inverse` is set.
- `no_inverse` output 1: set when gcd != 1, `e` == 0, or `phi` < 2.

## Operation
- States: IDLE, CHECK, DIV, UPDATE, FINAL.
- IDLE → CHECK on `start`. Loads r0=phi, r1=e, t0=0, t1=+1.
  - t0 and t1 are signed two's complement, WIDTH+1 bits.
- CHECK (1 cycle):
  - r1 == 0 → FINAL.
  - Otherwise → DIV.
- DIV (exactly WIDTH cycles): restoring divider computes q = r0 / r1 and rem = r0 % r1, one quotient bit per cycle, MSB first.
- UPDATE (1 cycle), then → CHECK:
  - r0←r1, r1←rem.
  - t0←t1, t1←t0 − q·t1.
  - The product is formed at 2·WIDTH+1 bits and truncated to WIDTH+1 bits. This is legal because |t| ≤ phi is invariant.
- FINAL (1 cycle), then → IDLE:
  - If r0 == 1 and phi ≥ 2: d = (t0 < 0) ? t0+phi : t0, with no_inverse=0.
  - Otherwise: d=0, no_inverse=1.
  - `done` is registered high on the following edge, for exactly one cycle.
- Operand corner cases:
  - e ≥ phi is legal: the first iteration has q=0 and swaps the operands.
  - e == 0 skips the loop (r0=phi ≠ 1 for phi ≥ 2) and gives no_inverse.
- `start` while busy is ignored; no queuing.
- `d`/`no_inverse` hold their values until the next FINAL.

## Timing
- Reset values: busy=0, done=0, d=0, no_inverse=0 (and gcd=0 when present); state=IDLE; internal registers cleared.
- Latency: with k = number of Euclid iterations, `done` is high k·(WIDTH+2)+2 cycles after the edge that samples `start`.
  - Example: e=7, phi=40, WIDTH=8: k=4 → 42 cycles.
- Back-to-back: a new `start` is accepted in the same cycle that `done` is high (state is IDLE by then).
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values; no `done` for the aborted request.

## Configuration
- Macro `MOD_INVERSE_GCD_OUT_EN`.
- Defined: adds output port `gcd` (WIDTH bits), updated in FINAL with the final r0. The top level can then cross-check the upstream GCD stage without a second GCD instance.
- Undefined: the port is absent; no other behaviour changes.

## Structure
- Shared package `pkd_pkg`:
  - State enum `mod_inv_state_t`.
  - Default `WIDTH` constant.
  - Signed coefficient typedef (WIDTH+1 bits).
- Sub-module `mod_inverse_div`: WIDTH-cycle restoring divider with ports `clk`, `rst_n`, `go`, `dividend`, `divisor`, `quot`, `rem`, `ready`.
  - The parent FSM drives `go` on entry to DIV and leaves DIV on `ready`.
  - The divider is never given divisor 0, because CHECK guards the loop.

## Test plan
- e=7, phi=40 → d=23, no_inverse=0, done pulse 42 cycles after start; gcd=1 when the macro is enabled.
- e=4, phi=54 (the pair used by the GCD stage bench) → no_inverse=1, d=0; gcd=2 when enabled.
- e=5, phi=72 → d=29. Then e=1, phi=10 → d=1, with the second `start` issued in the same cycle as the first `done`.
- e=0, phi=10 → no_inverse=1 after 2 cycles; e=3, phi=1 → no_inverse=1.
- e=3, phi=20 → d=7. A second `start` pulse (e=7, phi=40) during the run is ignored, and the result remains 7.
- rst_n pulled low at cycle 10 of an e=7, phi=40 run → outputs return to zero at once and no `done` is seen. A fresh start afterwards yields d=23.

Source files
------------

// File: rtl/pkd_pkg.sv
// Shared types and constants for the public-key decryption datapath.
package pkd_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      DIV,
      UPDATE,
      FINAL
   } mod_inv_state_t;

   // Bezout coefficient; one extra bit so that |t| <= phi stays representable.
   typedef logic signed [DEF_WIDTH:0] coef_t;

endpackage

// File: rtl/mod_inverse_div.sv
// Restoring divider, one quotient bit per cycle (MSB first), WIDTH cycles per divide.
// The first step is taken on the edge that samples go; ready is high once quot/rem are final.
module mod_inverse_div
   import pkd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             ready
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] divisor_q, divisor_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ready_q, ready_d;

   logic [WIDTH-1:0] src_rem;
   logic [WIDTH-1:0] src_quot;
   logic [WIDTH-1:0] src_div;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quot;

   // A negative trial difference (top bit set) means the divisor did not fit.
   always_comb begin
      src_rem   = go ? '0       : rem_q;
      src_quot  = go ? dividend : quot_q;
      src_div   = go ? divisor  : divisor_q;
      shifted   = {src_rem, src_quot[WIDTH-1]};
      diff      = shifted - {1'b0, src_div};
      step_rem  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_quot = {src_quot[WIDTH-2:0], ~diff[WIDTH]};
   end

   always_comb begin
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      if (go) begin
         divisor_d = divisor;
         rem_d     = step_rem;
         quot_d    = step_quot;
         cnt_d     = CW'(WIDTH - 1);
      end else if (cnt_q != '0) begin
         rem_d   = step_rem;
         quot_d  = step_quot;
         cnt_d   = cnt_q - CW'(1);
         ready_d = (cnt_q == CW'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
      end else begin
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
      end
   end

   assign quot  = quot_q;
   assign rem   = rem_q;
   assign ready = ready_q;

endmodule

// File: rtl/mod_inverse.sv
// Iterative extended-Euclid modular inverse: d = e^-1 mod phi, or no_inverse.
// Defining MOD_INVERSE_GCD_OUT_EN adds a gcd output carrying the final remainder r0.
module mod_inverse
   import pkd_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] phi,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             no_inverse
`ifdef MOD_INVERSE_GCD_OUT_EN
   ,
   output logic [WIDTH-1:0] gcd
`endif
);

   mod_inv_state_t state_q, state_d;

   logic [WIDTH-1:0]  r0_q, r0_d;
   logic [WIDTH-1:0]  r1_q, r1_d;
   logic [WIDTH-1:0]  phi_q, phi_d;
   logic signed [WIDTH:0] t0_q, t0_d;
   logic signed [WIDTH:0] t1_q, t1_d;
   logic [WIDTH-1:0]  d_q, d_d;
   logic              no_inv_q, no_inv_d;
   logic              done_q, done_d;

   logic              div_go;
   logic              div_ready;
   logic [WIDTH-1:0]  div_quot;
   logic [WIDTH-1:0]  div_rem;

   mod_inverse_div #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk     (clk),
      .rst_n   (rst_n),
      .go      (div_go),
      .dividend(r0_q),
      .divisor (r1_q),
      .quot    (div_quot),
      .rem     (div_rem),
      .ready   (div_ready)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CHECK;
         CHECK:   state_d = (r1_q == '0) ? FINAL : DIV;
         DIV:     if (div_ready) state_d = UPDATE;
         UPDATE:  state_d = CHECK;
         FINAL:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A zero remainder ends the loop before the divider could ever see divisor 0.
   always_comb begin
      busy   = (state_q != IDLE);
      div_go = (state_q == CHECK) && (r1_q != '0);
   end

   always_comb begin
      r0_d     = r0_q;
      r1_d     = r1_q;
      phi_d    = phi_q;
      t0_d     = t0_q;
      t1_d     = t1_q;
      d_d      = d_q;
      no_inv_d = no_inv_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               r0_d  = phi;
               r1_d  = e;
               phi_d = phi;
               t0_d  = '0;
               t1_d  = {{WIDTH{1'b0}}, 1'b1};
            end
         end
         UPDATE: begin
            r0_d = r1_q;
            r1_d = div_rem;
            t0_d = t1_q;
            // Truncating the wide product is safe: |t| never exceeds phi.
            t1_d = t0_q - (WIDTH+1)'($signed({{WIDTH{t1_q[WIDTH]}}, t1_q})
                                   * $signed({{(WIDTH+1){1'b0}}, div_quot}));
         end
         FINAL: begin
            done_d = 1'b1;
            if ((r0_q == WIDTH'(1)) && (phi_q >= WIDTH'(2))) begin
               no_inv_d = 1'b0;
               d_d      = t0_q[WIDTH] ? WIDTH'(t0_q + $signed({1'b0, phi_q}))
                                      : t0_q[WIDTH-1:0];
            end else begin
               no_inv_d = 1'b1;
               d_d      = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0_q     <= '0;
         r1_q     <= '0;
         phi_q    <= '0;
         t0_q     <= '0;
         t1_q     <= '0;
         d_q      <= '0;
         no_inv_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         r0_q     <= r0_d;
         r1_q     <= r1_d;
         phi_q    <= phi_d;
         t0_q     <= t0_d;
         t1_q     <= t1_d;
         d_q      <= d_d;
         no_inv_q <= no_inv_d;
         done_q   <= done_d;
      end
   end

   assign done       = done_q;
   assign d          = d_q;
   assign no_inverse = no_inv_q;

`ifdef MOD_INVERSE_GCD_OUT_EN
   logic [WIDTH-1:0] gcd_q, gcd_d;

   always_comb begin
      gcd_d = (state_q == FINAL) ? r0_q : gcd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcd_q <= '0;
      end else begin
         gcd_q <= gcd_d;
      end
   end

   assign gcd = gcd_q;
`endif

endmodule

// File: tb/tb_mod_inverse.sv
// Directed, scoreboard-checked bench for mod_inverse (WIDTH=8); gcd checked when
// MOD_INVERSE_GCD_OUT_EN is defined.
module tb_mod_inverse;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         ni;
      logic [W-1:0] g;
      int           lat;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] e;
   logic [W-1:0] phi;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         no_inverse;
`ifdef MOD_INVERSE_GCD_OUT_EN
   logic [W-1:0] gcd;
`endif

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mod_inverse #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .e         (e),
      .phi       (phi),
      .busy      (busy),
      .done      (done),
      .d         (d),
      .no_inverse(no_inverse)
`ifdef MOD_INVERSE_GCD_OUT_EN
      ,
      .gcd       (gcd)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: Euclid for gcd and iteration count, brute force for the inverse.
   function automatic exp_t model(input int ev, input int pv);
      exp_t r;
      int a, b, t, k;
      a = pv;
      b = ev;
      k = 0;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
         k++;
      end
      r.g   = a[W-1:0];
      r.lat = k * (W + 2) + 2;
      r.ni  = 1'b1;
      r.d   = '0;
      if (a == 1 && pv >= 2) begin
         for (int x = 0; x < pv; x++) begin
            if ((ev * x) % pv == 1) begin
               r.d  = x[W-1:0];
               r.ni = 1'b0;
            end
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drives a one-cycle start from a negedge; returns at the negedge after the sampling edge.
   task automatic applyStimulus(input int ev, input int pv, input bit push);
      if (push) sb.push_back(model(ev, pv));
      start = 1'b1;
      e     = ev[W-1:0];
      phi   = pv[W-1:0];
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic awaitResult(input string tag, input int cyc0, input bit pulse_check);
      exp_t x;
      int cyc;
      cyc = cyc0;
      while (done !== 1'b1 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      if (done !== 1'b1) begin
         checkOutput({tag, "_timeout"}, {31'b0, done}, 32'd1);
         if (sb.size() != 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         checkOutput({tag, "_unexpected_done"}, 32'd1, 32'd0);
         return;
      end
      x = sb.pop_front();
      checkOutput({tag, "_d"}, {24'b0, d}, {24'b0, x.d});
      checkOutput({tag, "_no_inverse"}, {31'b0, no_inverse}, {31'b0, x.ni});
      checkOutput({tag, "_latency"}, cyc, x.lat);
      checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
`ifdef MOD_INVERSE_GCD_OUT_EN
      checkOutput({tag, "_gcd"}, {24'b0, gcd}, {24'b0, x.g});
`endif
      if (pulse_check) begin
         @(negedge clk);
         checkOutput({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      end
   endtask

   task automatic countDones(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int seen;
      rst_n = 1'b1;
      start = 1'b0;
      e     = '0;
      phi   = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_d", {24'b0, d}, 32'd0);
      checkOutput("reset_no_inverse", {31'b0, no_inverse}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] e=7 phi=40");
      applyStimulus(7, 40, 1'b1);
      checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
      awaitResult("e7_phi40", 0, 1'b1);

      $display("[TB] e=4 phi=54");
      applyStimulus(4, 54, 1'b1);
      awaitResult("e4_phi54", 0, 1'b1);

      $display("[TB] e=5 phi=72 then back-to-back e=1 phi=10");
      applyStimulus(5, 72, 1'b1);
      awaitResult("e5_phi72", 0, 1'b0);
      applyStimulus(1, 10, 1'b1);
      awaitResult("e1_phi10", 0, 1'b1);

      $display("[TB] operand corner cases");
      applyStimulus(0, 10, 1'b1);
      awaitResult("e0_phi10", 0, 1'b1);
      applyStimulus(3, 1, 1'b1);
      awaitResult("e3_phi1", 0, 1'b1);
      applyStimulus(200, 7, 1'b1);
      awaitResult("e200_phi7", 0, 1'b1);

      $display("[TB] e=3 phi=20 with a start while busy");
      applyStimulus(3, 20, 1'b1);
      repeat (5) @(negedge clk);
      applyStimulus(7, 40, 1'b0);
      awaitResult("e3_phi20", 6, 1'b1);
      countDones(60, seen);
      checkOutput("ignored_start_no_done", seen, 0);
      checkOutput("d_hold", {24'b0, d}, 32'd7);

      $display("[TB] reset during e=7 phi=40");
      applyStimulus(7, 40, 1'b1);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_d", {24'b0, d}, 32'd0);
      checkOutput("abort_no_inverse", {31'b0, no_inverse}, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      countDones(60, seen);
      checkOutput("abort_no_done", seen, 0);

      applyStimulus(7, 40, 1'b1);
      awaitResult("after_abort", 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
